// File: rtl/seven_seg_capture.sv
// seven_seg_capture: samples a multiplexed 4-digit active-low seven-segment
// scan, decodes each settled digit back to BCD and publishes HH:MM frames.
//
// Ports:
//   clk, rst     clock, async active-high reset
//   seg[6:0]     segment lines, active low, bit0=a .. bit6=g
//   an[3:0]      anode lines, active low (0=min ones .. 3=hour tens)
//   digits       last published BCD frame {ht, ho, mt, mo}
//   hour_bin     binary hour, updated on error-free frames only
//   min_bin      binary minute, updated on error-free frames only
//   frame_valid  one-cycle pulse when a frame is published
//   frame_err    published frame held a blank or invalid digit
//   changed      pulse with frame_valid when hour_bin/min_bin change
//   scan_lost    no digit captured for TIMEOUT_CYCLES
module seven_seg_capture #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 500000,
  parameter int CNT_W          = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic [6:0]  hour_bin,
  output logic [6:0]  min_bin,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        changed,
  output logic        scan_lost
);

  localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_PRE = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_MAX     = CNT_W'(TIMEOUT_CYCLES);

  // Active-low pattern to BCD; F = blank, E = anything unrecognised.
  function automatic logic [3:0] seg_dec(input logic [6:0] s);
    logic [3:0] v;
    case (s)
      7'b1000000: v = 4'd0;
      7'b1111001: v = 4'd1;
      7'b0100100: v = 4'd2;
      7'b0110000: v = 4'd3;
      7'b0011001: v = 4'd4;
      7'b0010010: v = 4'd5;
      7'b0000010: v = 4'd6;
      7'b1111000: v = 4'd7;
      7'b0000000: v = 4'd8;
      7'b0010000: v = 4'd9;
      7'b1111111: v = 4'hF;
      default:    v = 4'hE;
    endcase
    return v;
  endfunction

  // Synchronizers and previous-cycle line snapshot
  logic [6:0]  seg_s1_q, seg_s2_q;
  logic [3:0]  an_s1_q, an_s2_q;
  logic [10:0] line_prev_q;

  // Stability / timeout counters
  logic [CNT_W-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] to_q, to_d;

  // Slot storage
  logic [3:0][3:0] val_q, val_d;
  logic [3:0]      err_q, err_d;
  logic [3:0]      mask_q, mask_d;

  // Registered outputs
  logic [15:0] digits_q, digits_d;
  logic [6:0]  hour_q, hour_d;
  logic [6:0]  min_q, min_d;
  logic        fv_q, fv_d;
  logic        ferr_q, ferr_d;
  logic        chg_q, chg_d;
  logic        lost_q, lost_d;

  // Decode / qualify
  logic       an_ok;
  logic [1:0] slot;
  logic       same;
  logic       cap;
  logic [3:0] dec;
  logic       timed_out;
  logic       publish;
  logic [6:0] hour_new;
  logic [6:0] min_new;

  always_comb begin
    an_ok = 1'b1;
    slot  = 2'd0;
    case (an_s2_q)
      4'b1110: slot = 2'd0;
      4'b1101: slot = 2'd1;
      4'b1011: slot = 2'd2;
      4'b0111: slot = 2'd3;
      default: an_ok = 1'b0;
    endcase
  end

  assign same = ({an_s2_q, seg_s2_q} == line_prev_q);
  assign dec  = seg_dec(seg_s2_q);

  // Fires once, on the edge where the counter reaches SETTLE_MAX; the
  // counter then saturates so a long dwell cannot re-trigger.
  assign cap = an_ok && same && (stable_q == SETTLE_PRE);

  always_comb begin
    stable_d = stable_q;
    if (!an_ok || !same)
      stable_d = '0;
    else if (stable_q != SETTLE_MAX)
      stable_d = stable_q + 1'b1;
  end

  assign timed_out = (to_q == TO_MAX);

  always_comb begin
    to_d = to_q;
    if (cap)
      to_d = '0;
    else if (!timed_out)
      to_d = to_q + 1'b1;
  end

  assign publish = (mask_q == 4'hF);

  // Clear on publish or timeout first; a capture in the same cycle then
  // lands in the freshly cleared mask.
  always_comb begin
    val_d  = val_q;
    err_d  = err_q;
    mask_d = mask_q;
    if (publish || timed_out) begin
      err_d  = '0;
      mask_d = '0;
    end
    if (cap) begin
      val_d[slot]  = dec;
      err_d[slot]  = (dec > 4'd9);
      mask_d[slot] = 1'b1;
    end
  end

  assign hour_new = ({3'b000, val_q[3]} * 7'd10) + {3'b000, val_q[2]};
  assign min_new  = ({3'b000, val_q[1]} * 7'd10) + {3'b000, val_q[0]};

  always_comb begin
    digits_d = digits_q;
    hour_d   = hour_q;
    min_d    = min_q;
    fv_d     = publish;
    ferr_d   = ferr_q;
    chg_d    = 1'b0;
    lost_d   = timed_out;
    if (publish) begin
      digits_d = val_q;
      ferr_d   = |err_q;
      if (!(|err_q)) begin
        hour_d = hour_new;
        min_d  = min_new;
        chg_d  = (hour_new != hour_q) || (min_new != min_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_s1_q    <= '0;
      seg_s2_q    <= '0;
      an_s1_q     <= '0;
      an_s2_q     <= '0;
      line_prev_q <= '0;
      stable_q    <= '0;
      to_q        <= '0;
      val_q       <= '0;
      err_q       <= '0;
      mask_q      <= '0;
      digits_q    <= '0;
      hour_q      <= '0;
      min_q       <= '0;
      fv_q        <= 1'b0;
      ferr_q      <= 1'b0;
      chg_q       <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      seg_s1_q    <= seg;
      seg_s2_q    <= seg_s1_q;
      an_s1_q     <= an;
      an_s2_q     <= an_s1_q;
      line_prev_q <= {an_s2_q, seg_s2_q};
      stable_q    <= stable_d;
      to_q        <= to_d;
      val_q       <= val_d;
      err_q       <= err_d;
      mask_q      <= mask_d;
      digits_q    <= digits_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      fv_q        <= fv_d;
      ferr_q      <= ferr_d;
      chg_q       <= chg_d;
      lost_q      <= lost_d;
    end
  end

  assign digits      = digits_q;
  assign hour_bin    = hour_q;
  assign min_bin     = min_q;
  assign frame_valid = fv_q;
  assign frame_err   = ferr_q;
  assign changed     = chg_q;
  assign scan_lost   = lost_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// tb_seven_seg_capture: directed scans of a seven-segment display
// against seven_seg_capture with hand-computed expected frames.
module tb_seven_seg_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg = 7'h7F;
  logic [3:0]  an  = 4'hF;
  logic [15:0] digits;
  logic [6:0]  hour_bin;
  logic [6:0]  min_bin;
  logic        frame_valid;
  logic        frame_err;
  logic        changed;
  logic        scan_lost;

  int checks = 0;
  int errors = 0;

  int          fv_cnt  = 0;
  int          chg_cnt = 0;
  logic [15:0] last_dig = '0;
  logic        last_err = 1'b0;
  logic        last_chg = 1'b0;

  int fv0;
  int chg0;

  seven_seg_capture #(
    .SETTLE_CYCLES (16),
    .TIMEOUT_CYCLES(10000),
    .CNT_W         (20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seg        (seg),
    .an         (an),
    .digits     (digits),
    .hour_bin   (hour_bin),
    .min_bin    (min_bin),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .changed    (changed),
    .scan_lost  (scan_lost)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid) begin
      fv_cnt   = fv_cnt + 1;
      last_dig = digits;
      last_err = frame_err;
      last_chg = changed;
    end
    if (changed)
      chg_cnt = chg_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] s;
    case (d)
      0: s = 7'b1000000;
      1: s = 7'b1111001;
      2: s = 7'b0100100;
      3: s = 7'b0110000;
      4: s = 7'b0011001;
      5: s = 7'b0010010;
      6: s = 7'b0000010;
      7: s = 7'b1111000;
      8: s = 7'b0000000;
      9: s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  task automatic drive(input logic [3:0] a, input logic [6:0] s,
                       input int n);
    an  = a;
    seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic show(input int sl, input logic [6:0] s, input int n);
    logic [3:0] a;
    a = 4'hF;
    a[sl] = 1'b0;
    drive(a, s, n);
  endtask

  task automatic scan_bcd(input int h1, input int h0, input int m1,
                          input int m0, input int n);
    show(0, seg_of(m0), n);
    show(1, seg_of(m1), n);
    show(2, seg_of(h0), n);
    show(3, seg_of(h1), n);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_fv", 32'(frame_valid), 32'h0);
    chk("rst_lost", 32'(scan_lost), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // 12:34, then an identical frame
    scan_bcd(1, 2, 3, 4, 200);
    chk("f1_cnt", 32'(fv_cnt), 32'd1);
    chk("f1_dig", 32'(last_dig), 32'h1234);
    chk("f1_err", 32'(last_err), 32'h0);
    chk("f1_chg", 32'(last_chg), 32'h1);
    chk("f1_hour", 32'(hour_bin), 32'd12);
    chk("f1_min", 32'(min_bin), 32'd34);
    scan_bcd(1, 2, 3, 4, 200);
    chk("f2_cnt", 32'(fv_cnt), 32'd2);
    chk("f2_chg", 32'(last_chg), 32'h0);
    chk("f2_lost", 32'(scan_lost), 32'h0);

    // Short dwell: nothing settles, timeout fires
    repeat (275) scan_bcd(1, 2, 3, 4, 10);
    chk("short_cnt", 32'(fv_cnt), 32'd2);
    chk("short_lost", 32'(scan_lost), 32'h1);
    scan_bcd(1, 2, 3, 4, 200);
    chk("rec_lost", 32'(scan_lost), 32'h0);
    chk("rec_cnt", 32'(fv_cnt), 32'd3);
    chk("rec_dig", 32'(last_dig), 32'h1234);
    chk("rec_chg", 32'(last_chg), 32'h0);

    // Blank hour tens in 09:05
    show(0, seg_of(5), 200);
    show(1, seg_of(0), 200);
    show(2, seg_of(9), 200);
    show(3, 7'b1111111, 200);
    chk("blk_cnt", 32'(fv_cnt), 32'd4);
    chk("blk_dig", 32'(last_dig), 32'hF905);
    chk("blk_err", 32'(last_err), 32'h1);
    chk("blk_chg", 32'(last_chg), 32'h0);
    chk("blk_hour", 32'(hour_bin), 32'd12);
    chk("blk_min", 32'(min_bin), 32'd34);

    // Unrecognised pattern on min ones
    show(0, 7'b0101010, 200);
    show(1, seg_of(3), 200);
    show(2, seg_of(2), 200);
    show(3, seg_of(1), 200);
    chk("inv_dig", 32'(last_dig), 32'h123E);
    chk("inv_err", 32'(last_err), 32'h1);
    chk("inv_out", 32'(frame_err), 32'h1);

    // Two anodes low mid-frame
    fv0 = fv_cnt;
    show(0, seg_of(4), 200);
    show(1, seg_of(3), 200);
    drive(4'b1100, seg_of(8), 300);
    chk("dbl_cnt", 32'(fv_cnt), 32'(fv0));
    show(2, seg_of(2), 200);
    show(3, seg_of(1), 200);
    chk("dbl_cnt2", 32'(fv_cnt), 32'(fv0 + 1));
    chk("dbl_dig", 32'(last_dig), 32'h1234);
    chk("dbl_err", 32'(last_err), 32'h0);

    // Reset with three slots captured
    show(0, seg_of(4), 200);
    show(1, seg_of(3), 200);
    show(2, seg_of(2), 200);
    drive(4'hF, 7'h7F, 5);
    rst = 1'b1;
    #1;
    chk("mr_digits", 32'(digits), 32'h0);
    chk("mr_hour", 32'(hour_bin), 32'h0);
    chk("mr_min", 32'(min_bin), 32'h0);
    chk("mr_err", 32'(frame_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    fv0 = fv_cnt;
    show(3, seg_of(1), 200);
    chk("mr_part", 32'(fv_cnt), 32'(fv0));
    show(0, seg_of(4), 200);
    show(1, seg_of(3), 200);
    chk("mr_part2", 32'(fv_cnt), 32'(fv0));
    show(2, seg_of(2), 200);
    chk("mr_cnt", 32'(fv_cnt), 32'(fv0 + 1));
    chk("mr_dig", 32'(last_dig), 32'h1234);
    chk("mr_chg", 32'(last_chg), 32'h1);

    // 12:34 -> 12:35 while min ones is on display
    chg0 = chg_cnt;
    show(0, seg_of(4), 100);
    show(0, seg_of(5), 100);
    show(1, seg_of(3), 200);
    show(2, seg_of(2), 200);
    show(3, seg_of(1), 200);
    chk("tc_dig", 32'(last_dig), 32'h1235);
    chk("tc_chg", 32'(last_chg), 32'h1);
    scan_bcd(1, 2, 3, 5, 200);
    chk("tc_chg2", 32'(last_chg), 32'h0);
    chk("tc_once", 32'(chg_cnt), 32'(chg0 + 1));
    chk("tc_min", 32'(min_bin), 32'd35);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_capture.md
Name: seven_seg_capture

Overview:
Receive-side counterpart of the multiplexed 4-digit seven-segment driver. It samples active-low segment and anode lines, decodes each scanned digit back to BCD, and assembles complete HH:MM frames. It then publishes binary hour/minute values with validity and error status. It sits in loopback self-test and board-monitor paths, fed either from the driver outputs or from synchronized pins.

Parameters:
SETTLE_CYCLES, 16, consecutive stable cycles required on anode+segment lines before a digit is captured (must be >=2).
TIMEOUT_CYCLES, 500000, cycles with no capture before scan_lost asserts (must exceed 4x driver dwell).
CNT_W, 20, width of settle/timeout counters; both parameters must be < 2^CNT_W.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
seg  in  7  segment lines, active low, bit0=a..bit6=g
an  in  4  anode lines, active low; an[0]=min ones, an[1]=min tens, an[2]=hour ones, an[3]=hour tens
digits  out  16  last published BCD frame {hour_tens, hour_ones, min_tens, min_ones}
hour_bin  out  7  hour_tens*10+hour_ones, updated only on error-free frames
min_bin  out  7  min_tens*10+min_ones, updated only on error-free frames
frame_valid  out  1  one-cycle pulse when a frame is published
frame_err  out  1  level, valid with frame_valid; published frame contained a blank or invalid digit
changed  out  1  one-cycle pulse, coincident with frame_valid, when hour_bin/min_bin take a new value
scan_lost  out  1  level, no capture for TIMEOUT_CYCLES

Behaviour:
- Reset (async): all outputs 0; digits=16'h0000; slot mask, counters, and synchronizers cleared; scan_lost=0.
- Input sync: seg and an each pass through 2-FF synchronizers. All logic below uses the synchronized copies. Latency is 2 cycles.
- Anode qualify: a scan is valid only if exactly one an bit is 0. For 4'b1111 or multiple low bits, stable_cnt is held at 0 and no capture occurs.
- Stability: stable_cnt increments each cycle the synced {an,seg} equals the previous cycle's value and the anode is valid. It resets to 0 on any change. It saturates at SETTLE_CYCLES.
- Capture: on the edge where stable_cnt reaches SETTLE_CYCLES, decode seg into the selected slot and set that slot's mask bit. Exactly one capture occurs per dwell, and no further capture happens until the lines change.
- Segment decode (active low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - 1111111 decodes to 4'hF (blank).
  - Any other pattern decodes to 4'hE (invalid).
  - Slot error bit is set when the decoded value is >9.
- Re-capture of a slot already in the mask overwrites its value and error bit; the mask is unchanged.
- Frame completion:
  - The cycle after the mask becomes 4'b1111, frame_valid=1 and digits is loaded from the slots.
  - frame_err is the OR of the slot error bits. The mask and error bits clear in the same cycle.
  - If frame_err=0, hour_bin and min_bin are loaded. changed=1 if either differs from its prior value.
  - If frame_err=1, hour_bin and min_bin hold and changed=0.
- Simultaneous capture of a slot while a frame is publishing: the new capture lands in the freshly cleared mask. Capture takes priority over the clear for that bit.
- Timeout:
  - to_cnt resets on every capture and otherwise increments.
  - When to_cnt reaches TIMEOUT_CYCLES, scan_lost=1 and the mask clears, so partial frames are discarded. to_cnt saturates.
  - scan_lost clears on the cycle after the next capture.
- Arithmetic: tens*10+ones is computed in 7 bits (max 99). No hour/minute range check is applied; 99:99 is accepted.
- Reset mid-frame discards all partial state.

Test Plan:
- SETTLE_CYCLES=16, TIMEOUT_CYCLES=10000. Drive the encoder scan of 12:34, dwell 200 cycles per digit, order an0..an3 -> after the 4th capture: frame_valid pulse, digits=16'h1234, hour_bin=12, min_bin=34, frame_err=0, changed=1; next identical frame gives changed=0.
- Dwell 10 cycles (< SETTLE_CYCLES) on every digit -> no capture, no frame_valid; scan_lost=1 after 10000 cycles; restore 200-cycle dwell -> scan_lost clears and the first frame after recovery is 12:34.
- Drive seg=7'b1111111 on an[3] in frame 09:05 -> frame_valid with frame_err=1, digits=16'hF905, hour_bin/min_bin unchanged; a pattern such as 7'b0101010 yields nibble E with frame_err=1.
- an=4'b1100 (two low) for 300 cycles mid-frame -> no capture in either slot; the frame completes correctly once single-hot scanning resumes.
- Assert rst after 3 slots captured -> all outputs 0 immediately; post-reset, 4 fresh captures are required before frame_valid.
- Change the driven time 12:34 -> 12:35 mid-scan -> at most one frame containing mixed digits, then 12:35 published with changed=1 exactly once.
